// File: rtl/mul_add_if.sv
// Start/busy/valid handshake bundle for the sequential multiply-accumulate unit.
// The master launches operands; the slave reports progress and the result.
interface mul_add_if #(
  parameter int WIDTH = 4
);
  logic                 start;
  logic                 busy;
  logic                 valid;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [WIDTH-1:0]     c;
  logic [2*WIDTH-1:0]   p;
  logic                 fits;

  modport master (output start, a, b, c, input busy, valid, p, fits);
  modport slave  (input start, a, b, c, output busy, valid, p, fits);
endinterface

// File: rtl/mul_add.sv
// Sequential radix-2 shift-add multiply-accumulate: p = a*b + c, one partial
// product per clock, WIDTH cycles from start to valid.
module mul_add #(
  parameter int WIDTH = 4
) (
  input  logic     clk,
  input  logic     rstn,
  mul_add_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, RUN} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic                 fits_q, fits_d;
  logic                 valid_q, valid_d;
  logic [2*WIDTH-1:0]   step;

  // One shift-add step; the sum keeps its carry, which lands in the top bit.
  function automatic logic [2*WIDTH-1:0] mac_step(input logic [WIDTH-1:0] hi,
                                                  input logic [WIDTH-1:0] lo,
                                                  input logic [WIDTH-1:0] bm);
    logic [WIDTH:0] sum;
    sum = {1'b0, hi} + (lo[0] ? {1'b0, bm} : {(WIDTH+1){1'b0}});
    return {sum, lo[WIDTH-1:1]};
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    b_d     = b_q;
    p_d     = p_q;
    fits_d  = fits_q;
    valid_d = valid_q;
    step    = mac_step(hi_q, lo_q, b_q);
    // start always wins, including over a completion on the same edge
    if (bus.start) begin
      state_d = RUN;
      valid_d = 1'b0;
      hi_d    = bus.c;
      lo_d    = bus.a;
      b_d     = bus.b;
      cnt_d   = CW'(WIDTH - 1);
    end else if (state_q == RUN) begin
      {hi_d, lo_d} = step;
      cnt_d        = cnt_q - 1'b1;
      if (cnt_q == '0) begin
        state_d = IDLE;
        valid_d = 1'b1;
        p_d     = step;
        fits_d  = (step[2*WIDTH-1:WIDTH] == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      p_q     <= '0;
      fits_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      b_q     <= b_d;
      p_q     <= p_d;
      fits_q  <= fits_d;
      valid_q <= valid_d;
    end
  end

  assign bus.busy  = (state_q == RUN);
  assign bus.valid = valid_q;
  assign bus.p     = p_q;
  assign bus.fits  = fits_q;
endmodule

// File: tb/tb_mul_add.sv
// Bench for mul_add: table vectors, random ops against a*b+c, handshake corner
// sequences, and a divide/multiply round-trip at WIDTH=8.
module tb_mul_add;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  mul_add_if #(.WIDTH(4)) bus4 ();
  mul_add_if #(.WIDTH(8)) bus8 ();

  mul_add #(.WIDTH(4)) dut4 (.clk(clk), .rstn(rstn), .bus(bus4));
  mul_add #(.WIDTH(8)) dut8 (.clk(clk), .rstn(rstn), .bus(bus8));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
    logic [7:0] p;
    logic       fits;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Launch on dut4 and wait for valid; reports latency and busy-cycle count.
  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                     output logic [7:0] p, output logic fits, output int lat, output int bcnt);
    @(negedge clk);
    bus4.start = 1'b1; bus4.a = a; bus4.b = b; bus4.c = c;
    @(negedge clk);
    bus4.start = 1'b0;
    lat = 1; bcnt = 0;
    if (bus4.busy) bcnt++;
    while (!bus4.valid && lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus4.busy) bcnt++;
    end
    lat = lat - 1;
    if (!bus4.valid) chk("op4_timeout", 0, 1);
    p = bus4.p; fits = bus4.fits;
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                     output logic [15:0] p, output logic fits, output int lat);
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.c = c;
    @(negedge clk);
    bus8.start = 1'b0;
    lat = 1;
    while (!bus8.valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    lat = lat - 1;
    if (!bus8.valid) chk("op8_timeout", 0, 1);
    p = bus8.p; fits = bus8.fits;
  endtask

  initial begin
    logic [7:0]  p4;
    logic [15:0] p8;
    logic        f;
    int          lat, bcnt, x, y;
    logic        saw30;
    logic        ok_hold;

    tbl[0] = '{a: 4'd13, b: 4'd11, c: 4'd7,  p: 8'd150, fits: 1'b0};
    tbl[1] = '{a: 4'd15, b: 4'd15, c: 4'd15, p: 8'd240, fits: 1'b0};
    tbl[2] = '{a: 4'd0,  b: 4'd15, c: 4'd9,  p: 8'd9,   fits: 1'b1};
    tbl[3] = '{a: 4'd1,  b: 4'd1,  c: 4'd0,  p: 8'd1,   fits: 1'b1};
    tbl[4] = '{a: 4'd15, b: 4'd0,  c: 4'd0,  p: 8'd0,   fits: 1'b1};

    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.c = '0;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.c = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus4.busy), 0);
    chk("rst_valid", 32'(bus4.valid), 0);
    chk("rst_p", 32'(bus4.p), 0);
    chk("rst_fits", 32'(bus4.fits), 0);
    chk("rst8_valid", 32'(bus8.valid), 0);
    rstn = 1'b1;

    // Table vectors
    for (int i = 0; i < 5; i++) begin
      op4(tbl[i].a, tbl[i].b, tbl[i].c, p4, f, lat, bcnt);
      chk($sformatf("tbl%0d_p", i), 32'(p4), 32'(tbl[i].p));
      chk($sformatf("tbl%0d_fits", i), 32'(f), 32'(tbl[i].fits));
      chk($sformatf("tbl%0d_lat", i), 32'(lat), 4);
      chk($sformatf("tbl%0d_busy_cycles", i), 32'(bcnt), 4);
      if (i == 0) begin
        ok_hold = 1'b1;
        repeat (10) begin
          @(negedge clk);
          if (bus4.p !== 8'd150 || bus4.valid !== 1'b1) ok_hold = 1'b0;
        end
        chk("hold_10_idle", 32'(ok_hold), 1);
      end
    end

    // Random ops against a*b+c
    for (int i = 0; i < 100; i++) begin
      logic [3:0] ra, rb, rc;
      int exp;
      ra = 4'($urandom_range(0, 15)); rb = 4'($urandom_range(0, 15)); rc = 4'($urandom_range(0, 15));
      exp = int'(ra) * int'(rb) + int'(rc);
      op4(ra, rb, rc, p4, f, lat, bcnt);
      chk("rand_p", 32'(p4), 32'(exp));
      chk("rand_fits", 32'(f), (exp < 16) ? 1 : 0);
    end

    // Restart while busy: 5*6+0 must never appear
    @(negedge clk);
    bus4.start = 1'b1; bus4.a = 4'd5; bus4.b = 4'd6; bus4.c = 4'd0;
    @(negedge clk);
    bus4.start = 1'b0;
    chk("restart_valid_low1", 32'(bus4.valid), 0);
    @(negedge clk);
    bus4.start = 1'b1; bus4.a = 4'd3; bus4.b = 4'd3; bus4.c = 4'd1;
    chk("restart_valid_low2", 32'(bus4.valid), 0);
    @(negedge clk);
    bus4.start = 1'b0;
    saw30 = 1'b0; lat = 1;
    while (!bus4.valid && lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus4.valid && bus4.p == 8'd30) saw30 = 1'b1;
    end
    chk("restart_lat", 32'(lat - 1), 4);
    chk("restart_p", 32'(bus4.p), 10);
    chk("restart_no30", 32'(saw30), 0);

    // Reset on the second busy cycle aborts
    @(negedge clk);
    bus4.start = 1'b1; bus4.a = 4'd7; bus4.b = 4'd9; bus4.c = 4'd2;
    @(negedge clk);
    bus4.start = 1'b0;
    @(negedge clk);
    chk("abort_busy_before", 32'(bus4.busy), 1);
    rstn = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(bus4.busy), 0);
    chk("abort_valid", 32'(bus4.valid), 0);
    chk("abort_p", 32'(bus4.p), 0);
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    chk("abort_no_result", 32'(bus4.valid), 0);
    op4(4'd2, 4'd3, 4'd1, p4, f, lat, bcnt);
    chk("after_reset_p", 32'(p4), 7);

    // Start on the edge valid would rise: first result suppressed
    @(negedge clk);
    bus4.start = 1'b1; bus4.a = 4'd9; bus4.b = 4'd9; bus4.c = 4'd0;
    @(negedge clk);
    bus4.start = 1'b0;
    repeat (3) @(negedge clk);
    bus4.start = 1'b1; bus4.a = 4'd4; bus4.b = 4'd5; bus4.c = 4'd3;
    @(negedge clk);
    bus4.start = 1'b0;
    chk("b2b_valid_suppressed", 32'(bus4.valid), 0);
    chk("b2b_p_unchanged", 32'(bus4.p), 7);
    lat = 1;
    while (!bus4.valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b_lat", 32'(lat - 1), 4);
    chk("b2b_p", 32'(bus4.p), 23);

    // Continuous start never completes
    @(negedge clk);
    bus4.start = 1'b1; bus4.a = 4'd1; bus4.b = 4'd1; bus4.c = 4'd1;
    ok_hold = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (bus4.valid !== 1'b0 || bus4.busy !== 1'b1) ok_hold = 1'b0;
    end
    bus4.start = 1'b0;
    chk("held_start_no_valid", 32'(ok_hold), 1);
    repeat (6) @(negedge clk);
    chk("held_start_release_p", 32'(bus4.p), 2);

    // Divide then rebuild the dividend at WIDTH=8
    for (int i = 0; i < 1000; i++) begin
      x = $urandom_range(0, 255);
      y = $urandom_range(1, 255);
      op8(8'(x / y), 8'(y), 8'(x % y), p8, f, lat);
      chk("rt_p", 32'(p8), 32'(x));
      chk("rt_fits", 32'(f), 1);
      if (i == 0) chk("rt_lat", 32'(lat), 8);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end
endmodule
